// File: rtl/div_sqrt_ctrl_pkg.sv
// div_sqrt_ctrl_pkg: FSM states, op encoding, flag bit indices and QNAN for the div/sqrt issue controller
package div_sqrt_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;
  localparam logic OP_DIV = 1'b0;
  localparam logic OP_SQRT = 1'b1;
  localparam int FLAG_OF = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_DZ = 2;
  localparam int FLAG_TO = 3;
  localparam logic [31:0] QNAN = 32'h7FC00000;
endpackage

// File: rtl/div_sqrt_req_fifo.sv
// div_sqrt_req_fifo: DEPTH-entry request queue, full/empty derived from registered occupancy only
module div_sqrt_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/div_sqrt_issue_ctrl.sv
// div_sqrt_issue_ctrl: queues div/sqrt requests, issues one at a time to the unit, returns tagged responses (WAIT timeout via DIV_SQRT_TIMEOUT_EN)
module div_sqrt_issue_ctrl
  import div_sqrt_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             Req_valid_SI,
  output logic             Req_ready_SO,
  input  logic             Req_op_SI,
  input  logic [31:0]      Req_a_DI,
  input  logic [31:0]      Req_b_DI,
  input  logic [1:0]       Req_rm_SI,
  input  logic [4:0]       Req_pc_SI,
  input  logic [TAG_W-1:0] Req_tag_DI,
  output logic             Resp_valid_SO,
  input  logic             Resp_ready_SI,
  output logic [31:0]      Resp_result_DO,
  output logic [3:0]       Resp_flags_DO,
  output logic [TAG_W-1:0] Resp_tag_DO,
  output logic             Div_start_SO,
  output logic             Sqrt_start_SO,
  output logic [31:0]      Operand_a_DO,
  output logic [31:0]      Operand_b_DO,
  output logic [1:0]       RM_SO,
  output logic [4:0]       Precision_ctl_SO,
  input  logic             Unit_ready_SI,
  input  logic             Unit_done_SI,
  input  logic [31:0]      Unit_result_DI,
  input  logic             Unit_exp_of_SI,
  input  logic             Unit_exp_uf_SI,
  input  logic             Unit_div_zero_SI,
  output logic             Busy_SO
);
  localparam int W = TAG_W + 72;
  localparam int RW = TAG_W + 36;
  state_e state_q, state_d;
  logic [W-1:0] iss_q, iss_d, head;
  logic [RW-1:0] resp_q, resp_d;
  logic start_q, start_d, pop, full, empty, to;
  logic [3:0] uflags, tflags;
  div_sqrt_req_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(Clk_CI),
    .rst(Rst_RI),
    .push(Req_valid_SI),
    .pop(pop),
    .din({Req_op_SI, Req_a_DI, Req_b_DI, Req_rm_SI, Req_pc_SI, Req_tag_DI}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
`ifdef DIV_SQRT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = state_q == ST_WAIT ? cnt_q + 1'b1 : '0;
  assign to = state_q == ST_WAIT && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge Clk_CI) cnt_q <= Rst_RI ? '0 : cnt_d;
`else
  assign to = 1'b0;
`endif
  always_comb begin
    uflags = '0;
    uflags[FLAG_OF] = Unit_exp_of_SI;
    uflags[FLAG_UF] = Unit_exp_uf_SI;
    uflags[FLAG_DZ] = Unit_div_zero_SI;
    tflags = '0;
    tflags[FLAG_TO] = 1'b1;
    state_d = state_q;
    iss_d = iss_q;
    resp_d = resp_q;
    start_d = 1'b0;
    pop = 1'b0;
    if (state_q == ST_IDLE && !empty && Unit_ready_SI) begin
      pop = 1'b1;
      iss_d = head;
      start_d = 1'b1;
      state_d = ST_WAIT;
    end else if (state_q == ST_WAIT && (Unit_done_SI || to)) begin
      resp_d = Unit_done_SI ? {Unit_result_DI, uflags, iss_q[TAG_W-1:0]} : {QNAN, tflags, iss_q[TAG_W-1:0]};
      state_d = ST_RESP;
    end else if (state_q == ST_RESP && Resp_ready_SI) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= ST_IDLE;
      iss_q <= '0;
      resp_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q <= iss_d;
      resp_q <= resp_d;
      start_q <= start_d;
    end
  end
  assign Req_ready_SO = !full;
  assign Busy_SO = state_q != ST_IDLE || !empty;
  assign Div_start_SO = start_q && iss_q[W-1] == OP_DIV;
  assign Sqrt_start_SO = start_q && iss_q[W-1] == OP_SQRT;
  assign Operand_a_DO = iss_q[TAG_W+39 +: 32];
  assign Operand_b_DO = iss_q[TAG_W+7 +: 32];
  assign RM_SO = iss_q[TAG_W+5 +: 2];
  assign Precision_ctl_SO = iss_q[TAG_W +: 5];
  assign Resp_valid_SO = state_q == ST_RESP;
  assign Resp_result_DO = resp_q[RW-1 -: 32];
  assign Resp_flags_DO = resp_q[TAG_W +: 4];
  assign Resp_tag_DO = resp_q[TAG_W-1:0];
endmodule

// File: tb/tb_div_sqrt_issue_ctrl.sv
// tb_div_sqrt_issue_ctrl: table-driven scoreboard bench with a latency-modelled unit and directed corner sequences
module tb_div_sqrt_issue_ctrl;
  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [4:0]  pc;
    logic [3:0]  tag;
    int          lat;
    logic [31:0] res;
    logic [2:0]  uf3;
    logic [3:0]  flags;
  } vec_t;
  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } rsp_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_op = 0, resp_rdy = 1, unit_rdy = 1;
  logic [31:0] req_a = 0, req_b = 0;
  logic [1:0] req_rm = 0;
  logic [4:0] req_pc = 0;
  logic [3:0] req_tag = 0;
  logic m_done = 0, h_done = 0, m_en = 0, pend = 0;
  logic [31:0] m_res = 0, h_res = 0;
  logic [2:0] m_f = 0;
  int nvec = 0, errs = 0;
  vec_t exp_iss[$];
  rsp_t exp_rsp[$];
  logic Req_ready_SO, Resp_valid_SO, Div_start_SO, Sqrt_start_SO, Busy_SO;
  logic [31:0] Resp_result_DO, Operand_a_DO, Operand_b_DO;
  logic [3:0] Resp_flags_DO, Resp_tag_DO;
  logic [1:0] RM_SO;
  logic [4:0] Precision_ctl_SO;
  always #5 clk = ~clk;
  div_sqrt_issue_ctrl #(.DEPTH(2), .TAG_W(4), .TIMEOUT_CYCLES(64)) dut (
    .Clk_CI(clk),
    .Rst_RI(rst),
    .Req_valid_SI(req_valid),
    .Req_ready_SO(Req_ready_SO),
    .Req_op_SI(req_op),
    .Req_a_DI(req_a),
    .Req_b_DI(req_b),
    .Req_rm_SI(req_rm),
    .Req_pc_SI(req_pc),
    .Req_tag_DI(req_tag),
    .Resp_valid_SO(Resp_valid_SO),
    .Resp_ready_SI(resp_rdy),
    .Resp_result_DO(Resp_result_DO),
    .Resp_flags_DO(Resp_flags_DO),
    .Resp_tag_DO(Resp_tag_DO),
    .Div_start_SO(Div_start_SO),
    .Sqrt_start_SO(Sqrt_start_SO),
    .Operand_a_DO(Operand_a_DO),
    .Operand_b_DO(Operand_b_DO),
    .RM_SO(RM_SO),
    .Precision_ctl_SO(Precision_ctl_SO),
    .Unit_ready_SI(unit_rdy),
    .Unit_done_SI(m_done | h_done),
    .Unit_result_DI(m_res | h_res),
    .Unit_exp_of_SI(m_f[0]),
    .Unit_exp_uf_SI(m_f[1]),
    .Unit_div_zero_SI(m_f[2]),
    .Busy_SO(Busy_SO)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    req_valid = 1;
    req_op = v.op;
    req_a = v.a;
    req_b = v.b;
    req_rm = v.rm;
    req_pc = v.pc;
    req_tag = v.tag;
  endtask
  task automatic send(input vec_t v, input bit track);
    int t;
    rsp_t r;
    t = 0;
    drive(v);
    @(negedge clk);
    while (!Req_ready_SO && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk("req_accept", Req_ready_SO, 1);
    if (track) begin
      r.res = v.res;
      r.flags = v.flags;
      r.tag = v.tag;
      exp_iss.push_back(v);
      exp_rsp.push_back(r);
    end
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_rsp.size() != 0 || Busy_SO) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_rsp.size(), 0);
    chk("idle_busy", Busy_SO, 0);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_start();
    int t;
    t = 0;
    @(negedge clk);
    while (!(Div_start_SO || Sqrt_start_SO) && t < 50) begin
      t++;
      @(negedge clk);
    end
  endtask
  initial begin : unit_model
    vec_t e;
    forever begin
      @(negedge clk);
      if (m_en && (Div_start_SO || Sqrt_start_SO)) begin
        chk("start_overlap", pend, 0);
        pend = 1;
        chk("iss_avail", exp_iss.size() > 0, 1);
        if (exp_iss.size() > 0) begin
          e = exp_iss.pop_front();
          chk("sqrt_start", Sqrt_start_SO, e.op);
          chk("div_start", Div_start_SO, !e.op);
          chk("opnd_a", Operand_a_DO, e.a);
          chk("opnd_b", Operand_b_DO, e.b);
          chk("rm", RM_SO, e.rm);
          chk("pc", Precision_ctl_SO, e.pc);
          @(negedge clk);
          chk("start_pulse", Div_start_SO || Sqrt_start_SO, 0);
          repeat (e.lat - 1) @(posedge clk);
          #1;
          chk("opnd_hold", {Operand_a_DO, Operand_b_DO}, {e.a, e.b});
          m_done = 1;
          m_res = e.res;
          m_f = e.uf3;
          @(posedge clk);
          #1;
          m_done = 0;
          m_res = 0;
          m_f = 0;
        end
      end
    end
  end
  initial begin : resp_mon
    rsp_t r;
    forever begin
      @(negedge clk);
      if (Resp_valid_SO && resp_rdy) begin
        chk("rsp_avail", exp_rsp.size() > 0, 1);
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          chk("rsp_result", Resp_result_DO, r.res);
          chk("rsp_flags", Resp_flags_DO, r.flags);
          chk("rsp_tag", Resp_tag_DO, r.tag);
        end
        pend = 0;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin : main
    vec_t tbl [6];
    vec_t v, v3;
    int t;
    tbl[0] = '{0, 32'h40400000, 32'h3F800000, 2'd0, 5'd23, 4'd3, 12, 32'h40400000, 3'b000, 4'b0000};
    tbl[1] = '{0, 32'h3F800000, 32'h00000000, 2'd1, 5'd10, 4'd4, 3, 32'h7F800000, 3'b100, 4'b0100};
    tbl[2] = '{1, 32'h40800000, 32'h00000000, 2'd2, 5'd5, 4'd5, 1, 32'h40000000, 3'b000, 4'b0000};
    tbl[3] = '{0, 32'h7F000000, 32'h00800000, 2'd3, 5'd23, 4'd6, 5, 32'h7F800000, 3'b001, 4'b0001};
    tbl[4] = '{0, 32'h00800000, 32'h7F000000, 2'd0, 5'd7, 4'd7, 2, 32'h00000000, 3'b010, 4'b0010};
    tbl[5] = '{1, 32'h41100000, 32'h00000000, 2'd1, 5'd11, 4'd15, 7, 32'h40400000, 3'b000, 4'b0000};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req_ready", Req_ready_SO, 1);
    chk("rst_resp_valid", Resp_valid_SO, 0);
    chk("rst_busy", Busy_SO, 0);
    chk("rst_start", Div_start_SO || Sqrt_start_SO, 0);
    chk("rst_opnd", {Operand_a_DO, Operand_b_DO}, 64'h0);
    chk("rst_resp", {Resp_result_DO, Resp_flags_DO, Resp_tag_DO}, 40'h0);
    @(posedge clk);
    #1 m_en = 1;
    for (int i = 0; i < 6; i++) send(tbl[i], 1);
    wait_drain();
    h_done = 1;
    h_res = 32'hDEADBEEF;
    @(negedge clk);
    chk("stray_done_valid", Resp_valid_SO, 0);
    @(posedge clk);
    #1 h_done = 0;
    h_res = 0;
    @(negedge clk);
    chk("stray_done_busy", Busy_SO, 0);
    @(posedge clk);
    #1 resp_rdy = 0;
    v = '{1, 32'h40800000, 32'h00000000, 2'd1, 5'd23, 4'd2, 2, 32'h40000000, 3'b000, 4'b0000};
    send(v, 1);
    v = '{0, 32'h3F800000, 32'h40000000, 2'd0, 5'd23, 4'd8, 1, 32'h3F000000, 3'b000, 4'b0000};
    send(v, 1);
    t = 0;
    @(negedge clk);
    while (!Resp_valid_SO && t < 100) begin
      t++;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", Resp_valid_SO, 1);
      chk("stall_result", Resp_result_DO, 32'h40000000);
      chk("stall_flags_tag", {Resp_flags_DO, Resp_tag_DO}, 8'h02);
      chk("stall_nostart", Div_start_SO || Sqrt_start_SO, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_rdy = 1;
    wait_drain();
    unit_rdy = 0;
    v = '{0, 32'h40A00000, 32'h40000000, 2'd0, 5'd23, 4'd1, 3, 32'h40200000, 3'b000, 4'b0000};
    send(v, 1);
    v = '{1, 32'h41800000, 32'h00000000, 2'd2, 5'd10, 4'd2, 2, 32'h40800000, 3'b000, 4'b0000};
    send(v, 1);
    v3 = '{0, 32'h40C00000, 32'h40400000, 2'd3, 5'd5, 4'd3, 4, 32'h40000000, 3'b000, 4'b0000};
    drive(v3);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("full_ready", Req_ready_SO, 0);
      chk("full_busy", Busy_SO, 1);
      chk("full_nostart", Div_start_SO || Sqrt_start_SO, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 unit_rdy = 1;
    send(v3, 1);
    wait_drain();
    m_en = 0;
    v = '{0, 32'h40A00000, 32'h40000000, 2'd2, 5'd23, 4'd12, 1, 32'h0, 3'b000, 4'b0000};
    send(v, 0);
    wait_start();
    chk("to_start", Div_start_SO, 1);
`ifdef DIV_SQRT_TIMEOUT_EN
    begin
      rsp_t r;
      r.res = 32'h7FC00000;
      r.flags = 4'b1000;
      r.tag = 4'd12;
      exp_rsp.push_back(r);
    end
    t = 0;
    while (!Resp_valid_SO && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("to_cycles", t, 64);
    wait_drain();
    h_done = 1;
    h_res = 32'h3F800000;
    @(posedge clk);
    #1 h_done = 0;
    h_res = 0;
    @(negedge clk);
    chk("late_done_valid", Resp_valid_SO, 0);
    chk("late_done_busy", Busy_SO, 0);
    @(posedge clk);
    #1;
`else
    repeat (100) @(negedge clk);
    chk("nto_valid", Resp_valid_SO, 0);
    chk("nto_busy", Busy_SO, 1);
    begin
      rsp_t r;
      r.res = 32'h3F000000;
      r.flags = 4'b0000;
      r.tag = 4'd12;
      exp_rsp.push_back(r);
    end
    @(posedge clk);
    #1 h_done = 1;
    h_res = 32'h3F000000;
    @(posedge clk);
    #1 h_done = 0;
    h_res = 0;
    wait_drain();
`endif
    v = '{1, 32'h40800000, 32'h00000000, 2'd0, 5'd23, 4'd13, 1, 32'h0, 3'b000, 4'b0000};
    send(v, 0);
    wait_start();
    chk("rw_start", Sqrt_start_SO, 1);
    @(posedge clk);
    #1;
    v = '{0, 32'h40400000, 32'h3F800000, 2'd1, 5'd23, 4'd14, 1, 32'h0, 3'b000, 4'b0000};
    send(v, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rw_resp_valid", Resp_valid_SO, 0);
    chk("rw_req_ready", Req_ready_SO, 1);
    chk("rw_busy", Busy_SO, 0);
    chk("rw_opnd", {Operand_a_DO, Operand_b_DO}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rw_nostart", Div_start_SO || Sqrt_start_SO, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 m_en = 1;
    send(tbl[3], 1);
    wait_drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule

// File: doc/div_sqrt_issue_ctrl.md
DIV_SQRT_ISSUE_CTRL -- requirements
Module: div_sqrt_issue_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, 2, request FIFO entries (power of 2, >=2); TAG_W, 4, request tag width; TIMEOUT_CYCLES, 64, cycles in WAIT before timeout.
REQ-002 Ports SHALL be, one clock, reset synchronous and active-high: Clk_CI in 1 clock; Rst_RI in 1 sync active-high reset.
REQ-003 Request side SHALL be: Req_valid_SI in 1; Req_ready_SO out 1; Req_op_SI in 1 (0=div, 1=sqrt); Req_a_DI in 32; Req_b_DI in 32; Req_rm_SI in 2; Req_pc_SI in 5; Req_tag_DI in TAG_W.
REQ-004 Response side SHALL be: Resp_valid_SO out 1; Resp_ready_SI in 1; Resp_result_DO out 32; Resp_flags_DO out 4 ({timeout, div_zero, uf, of}); Resp_tag_DO out TAG_W.
REQ-005 Unit side SHALL be: Div_start_SO, Sqrt_start_SO out 1; Operand_a_DO, Operand_b_DO out 32; RM_SO out 2; Precision_ctl_SO out 5; Unit_ready_SI, Unit_done_SI in 1; Unit_result_DI in 32; Unit_exp_of_SI, Unit_exp_uf_SI, Unit_div_zero_SI in 1; Busy_SO out 1.

Function
REQ-006 Request accepted when Req_valid_SI && Req_ready_SO at rising edge; Req_ready_SO = !fifo_full, registered-state based only (no push on a full cycle even if a pop occurs).
REQ-007 FSM SHALL have states IDLE, WAIT, RESP.
REQ-008 IDLE: if FIFO non-empty and Unit_ready_SI=1, pop head, assert Div_start_SO (op=0) or Sqrt_start_SO (op=1) for exactly one cycle, -> WAIT.
REQ-009 Operand_a/b_DO, RM_SO, Precision_ctl_SO SHALL be driven from an issue register loaded at pop, valid in the start cycle, stable until leaving WAIT.
REQ-010 WAIT: on Unit_done_SI=1 capture Unit_result_DI, flags and issued tag into response register, -> RESP next cycle.
REQ-011 RESP: Resp_valid_SO=1, response fields held stable until Resp_valid_SO && Resp_ready_SI; then -> IDLE; next issue no earlier than the following cycle.
REQ-012 Unit_done_SI outside WAIT SHALL be ignored; never two starts without an intervening done/timeout.
REQ-013 Busy_SO = (state != IDLE) || FIFO non-empty.
REQ-014 Requests SHALL issue in acceptance order; tag returned unmodified; FIFO pointers wrap modulo DEPTH.

Reset
REQ-015 Rst_RI high at a rising edge SHALL force IDLE, empty FIFO, clear issue/response registers; all outputs 0 except Req_ready_SO=1 from first cycle after reset.
REQ-016 Reset mid-WAIT or mid-RESP SHALL discard the in-flight operation; the integrator holds the unit in reset concurrently (Rst_RBI = !Rst_RI).

Configuration
REQ-017 Macro DIV_SQRT_TIMEOUT_EN defined: WAIT counter from 0; at TIMEOUT_CYCLES-1 with no done -> RESP with result 32'h7FC00000, flags 4'b1000; late done ignored.
REQ-018 Macro undefined: no counter, flags[3] tied 0, WAIT lasts until Unit_done_SI.

Structure
REQ-019 Package div_sqrt_ctrl_pkg SHALL hold FSM state enum, op encoding, flag bit indices, QNAN constant 32'h7FC00000.
REQ-020 Sub-module div_sqrt_req_fifo (DEPTH x {op,a,b,rm,pc,tag}, push/pop/full/empty) SHALL hold the request queue.

Verification
REQ-021 Div 0x40400000/0x3F800000 tag 3, unit done 12 cycles later with 0x40400000 -> one-cycle Div_start_SO, Resp result 0x40400000 tag 3 flags 0.
REQ-022 Sqrt a=0x40800000, Resp_ready_SI low 5 cycles -> Resp fields stable 5 cycles, no new start until handshake.
REQ-023 Push 3 requests back-to-back with DEPTH=2, unit not ready -> Req_ready_SO low after 2 accepts; third accepted only after first pop; responses in tag order.
REQ-024 Div by zero, unit done with Unit_div_zero_SI=1 result 0x7F800000 -> flags 4'b0100.
REQ-025 DIV_SQRT_TIMEOUT_EN, done never asserted -> Resp 0x7FC00000 flags 4'b1000 after 64 WAIT cycles; later done ignored.
REQ-026 Rst_RI pulsed in WAIT -> next cycle IDLE, FIFO empty, Resp_valid_SO=0, Req_ready_SO=1.
